instruction_memory_loader: RTL and testbench
============================================

// Module: instruction_memory_loader
// PURPOSE
// Writes a program into the instruction memory from a byte stream; the memory itself only reads.
// Runs at boot or on demand. While it runs it holds the CPU in reset and drives the memory write port.
// Stream format: 2-byte word count N (big-endian), then 4*N data bytes, then 1 XOR checksum byte.
// Data bytes are big-endian: the first byte is instr[31:24].
// PARAMETERS
// ADDR_WIDTH   8   word-address width; capacity is 2**ADDR_WIDTH words (256)
// PORTS
// clk        in   1           rising-edge clock
// reset_n    in   1           asynchronous active-low reset
// start      in   1           one-cycle pulse that begins a load session; ignored while busy
// rx_data    in   8           stream byte
// rx_valid   in   1           rx_data is valid
// rx_ready   out  1           loader accepts a byte this cycle (transfer = rx_valid & rx_ready)
// mem_we     out  1           one-cycle instruction-memory write strobe
// mem_addr   out  ADDR_WIDTH  word index of the write
// mem_wdata  out  32          instruction word to write
// cpu_hold   out  1           holds the CPU in reset while high
// busy       out  1           session in progress
// done       out  1           one-cycle pulse at the end of a session
// error      out  1           sticky; cleared by the next accepted start
// BEHAVIOUR
// - reset_n low: state=IDLE; every output is 0; byte counter, word counter and checksum are cleared.
//   Applies mid-session too: a partial load leaves the memory contents as written so far.
// - All outputs are registered. rx_ready=1 only in LEN_HI, LEN_LO, DATA and CHK.
// - busy=cpu_hold=1 in every state except IDLE.
// - IDLE: start=1 -> LEN_HI; clear error, checksum and counters.
// - LEN_HI: on transfer, latch N[15:8] -> LEN_LO.
// - LEN_LO: on transfer, latch N[7:0]. Then:
//   - N=0 -> CHK.
//   - N > 2**ADDR_WIDTH -> error=1, done pulse, IDLE. No writes; the remaining stream is not consumed.
//   - otherwise -> DATA.
// - DATA: each transfer shifts rx_data into a 32-bit assembly register and XORs it into the checksum.
// - DATA, 4th byte of a word: in the next cycle mem_we=1, mem_addr=word index (starts at 0, +1 per word),
//   mem_wdata=assembled word.
// - DATA: rx_ready stays 1 during the write cycle, so back-to-back bytes run at full rate.
// - DATA: after word N-1 is assembled -> CHK.
// - CHK: on transfer, compare rx_data with the checksum; mismatch -> error=1. Either way -> DONE.
// - DONE: done=1 for exactly 1 cycle -> IDLE. cpu_hold falls on the same edge that leaves DONE.
// - Gaps in rx_valid stall the state machine; no timeout.
// - start while busy is ignored. start on the same cycle as reset_n low: reset wins.
// - mem_addr wraps never occurs: N is bounded by the overflow check.
//   N=2**ADDR_WIDTH writes index 2**ADDR_WIDTH-1 last.
// TESTING
// 1 reset_n=0 with rx_valid=1 -> every output 0, rx_ready=0; after release, stays IDLE until start.
// 2 start; bytes 00 02 20 08 00 05 00 00 00 0C 21 -> writes 0x20080005@0, 0x0000000C@1;
//   done pulses; error=0; cpu_hold low after done.
// 3 same stream with checksum 22 -> same two writes, done pulses, error=1 (held until next start).
// 4 start; bytes 00 00 00 -> no mem_we; done pulses; error=0.
// 5 ADDR_WIDTH=8, start; bytes 01 01 -> error=1, done pulses, no writes, rx_ready=0 after.
// 6 case 2 stream with random 0-3 cycle rx_valid gaps -> identical writes.
//   Then reset_n=0 after word 0: all outputs 0, and a new start loads correctly.

Source files
------------

// File: rtl/instruction_memory_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = stream source plus memory.
interface instruction_memory_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// Loads a program into instruction memory from a byte stream:
// 16-bit big-endian word count, 4*N big-endian data bytes, XOR checksum byte.
module instruction_memory_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  instruction_memory_loader_if.master     bus,
  output logic                            cpu_hold,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_DONE
  } state_t;

  localparam logic [16:0]           CAPACITY = 17'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   WORD_ONE = 1;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH:0]   word_q, word_d;
  logic [1:0]            byte_q, byte_d;
  logic [23:0]           asm_q, asm_d;
  logic [7:0]            chk_q, chk_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  xfer;
  logic [15:0]           len_rx;

  assign xfer   = bus.rx_valid & rx_ready_q;
  assign len_rx = {len_q[15:8], bus.rx_data};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_d      = word_q;
    byte_d      = byte_q;
    asm_d       = asm_q;
    chk_d       = chk_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    error_d     = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEN_HI;
          error_d = 1'b0;
          chk_d   = '0;
          word_d  = '0;
          byte_d  = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = bus.rx_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_rx;
          if (len_rx == 16'd0) begin
            state_d = S_CHK;
          end else if ({1'b0, len_rx} > CAPACITY) begin
            // Oversized program: abort before touching memory, leave the rest of the stream unread.
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          chk_d  = chk_q ^ bus.rx_data;
          asm_d  = {asm_q[15:0], bus.rx_data};
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_q[ADDR_WIDTH-1:0];
            mem_wdata_d = {asm_q, bus.rx_data};
            word_d      = word_q + WORD_ONE;
            if (17'(word_q) + 17'd1 == {1'b0, len_q}) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          if (bus.rx_data != chk_q) error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the next-state decode.
    rx_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                 (state_d == S_DATA)   || (state_d == S_CHK);
    busy_d     = (state_d != S_IDLE);
    done_d     = done_d | (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_q      <= '0;
      byte_q      <= '0;
      asm_q       <= '0;
      chk_q       <= '0;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_q      <= word_d;
      byte_q      <= byte_d;
      asm_q       <= asm_d;
      chk_q       <= chk_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = busy_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader: byte streams in, memory writes
// and status pulses checked against hand-computed values.
module tb_instruction_memory_loader;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, busy, done, error;

  instruction_memory_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_memory_loader #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus.master),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int unsigned    we_cnt = 0;
  int unsigned    done_cnt = 0;
  logic [31:0]    wr_data[$];
  logic [AW-1:0]  wr_addr[$];
  logic [7:0]     stream[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      we_cnt++;
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    we_cnt = 0;
    done_cnt = 0;
    wr_data.delete();
    wr_addr.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned w;
    for (int unsigned g = 0; g < gap; g++) begin
      bus.rx_valid = 1'b0;
      @(negedge clk);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    w = 0;
    while (bus.rx_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("rx_ready_timeout", 64'(bus.rx_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic send_stream(input int unsigned max_gap);
    for (int unsigned i = 0; i < stream.size(); i++)
      send_byte(stream[i], (max_gap == 0) ? 0 : $urandom_range(0, max_gap));
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({bus.rx_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                    cpu_hold, busy, done, error}), 64'd0);
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_we_cnt"}, 64'(we_cnt), 64'd2);
    check({tag, "_addr0"},  64'(wr_addr[0]), 64'd0);
    check({tag, "_data0"},  64'(wr_data[0]), 64'h2008_0005);
    check({tag, "_addr1"},  64'(wr_addr[1]), 64'd1);
    check({tag, "_data1"},  64'(wr_data[1]), 64'h0000_000C);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset dominates start and rx_valid
    bus.rx_data  = 8'hFF;
    bus.rx_valid = 1'b1;
    start        = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    reset_n      = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("idle_no_we", 64'(we_cnt), 64'd0);

    // 2: two-word load, good checksum
    clear_log();
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    check("start_cpu_hold", 64'(cpu_hold), 64'd1);
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h21};
    send_stream(0);
    check("ok_done_pulse", 64'(done), 64'd1);
    check("ok_hold_in_done", 64'(cpu_hold), 64'd1);
    @(negedge clk);
    check("ok_done_low", 64'(done), 64'd0);
    check("ok_hold_low", 64'(cpu_hold), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check_two_writes("ok");
    check("ok_done_cnt", 64'(done_cnt), 64'd1);
    check("ok_error", 64'(error), 64'd0);

    // 3: bad checksum, sticky error
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h22};
    send_stream(0);
    check("bad_done_pulse", 64'(done), 64'd1);
    check("bad_error", 64'(error), 64'd1);
    repeat (5) @(negedge clk);
    #1;
    check_two_writes("bad");
    check("bad_done_cnt", 64'(done_cnt), 64'd1);
    check("bad_error_sticky", 64'(error), 64'd1);

    // 4: empty program
    clear_log();
    pulse_start();
    check("empty_error_cleared", 64'(error), 64'd0);
    stream = '{8'h00, 8'h00, 8'h00};
    send_stream(0);
    check("empty_done_pulse", 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    check("empty_no_we", 64'(we_cnt), 64'd0);
    check("empty_done_cnt", 64'(done_cnt), 64'd1);
    check("empty_error", 64'(error), 64'd0);

    // 5: N = 257 exceeds 256-word capacity
    clear_log();
    pulse_start();
    stream = '{8'h01, 8'h01};
    send_stream(0);
    check("ovf_done_pulse", 64'(done), 64'd1);
    check("ovf_error", 64'(error), 64'd1);
    check("ovf_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("ovf_busy", 64'(busy), 64'd0);
    bus.rx_data  = 8'h55;
    bus.rx_valid = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("ovf_not_consumed", 64'(bus.rx_ready), 64'd0);
    check("ovf_no_we", 64'(we_cnt), 64'd0);
    check("ovf_done_cnt", 64'(done_cnt), 64'd1);
    bus.rx_valid = 1'b0;

    // 6: rx_valid gaps, then reset mid-session and reload
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h21};
    send_stream(3);
    repeat (4) @(negedge clk);
    #1;
    check_two_writes("gap");
    check("gap_done_cnt", 64'(done_cnt), 64'd1);
    check("gap_error", 64'(error), 64'd0);

    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
    send_stream(0);
    @(negedge clk);
    #1;
    check("mid_we_cnt", 64'(we_cnt), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset_outputs");
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h21};
    send_stream(0);
    repeat (3) @(negedge clk);
    #1;
    check_two_writes("reload");
    check("reload_done_cnt", 64'(done_cnt), 64'd1);
    check("reload_error", 64'(error), 64'd0);
    check("reload_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
